// File: rtl/roll_pkg.sv
// roll_pkg: shared LCG constants, channel state type and display-value extraction
package roll_pkg;
    localparam logic [30:0] LCG_MUL = 31'd1103515245;
    localparam logic [30:0] LCG_INC = 31'd12345;
    typedef enum logic [1:0] {IDLE, WAIT, REQ} ch_state_e;
    function automatic logic [3:0] extract(logic [30:0] s);
        return {s[15], s[14], s[3], s[13]};
    endfunction
endpackage

// File: rtl/lcg_step.sv
// lcg_step: one combinational LCG advance plus the 4-bit value drawn from the new state
module lcg_step
    import roll_pkg::*;
(
    input  logic [30:0] state,
    output logic [30:0] next,
    output logic [3:0]  value
);
    assign next  = state * LCG_MUL + LCG_INC;
    assign value = extract(next);
endmodule

// File: rtl/roll_scheduler.sv
// roll_scheduler: per-channel decelerating roll FSMs sharing one LCG through a round-robin arbiter
module roll_scheduler
    import roll_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int STEPS      = 13,
    parameter int BASE_TICKS = 12_500_000,
    parameter int CNT_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_CH-1:0]   i_start,
    input  logic              i_seed_load,
    input  logic [30:0]       i_seed,
    output logic [4*N_CH-1:0] o_value,
    output logic [N_CH-1:0]   o_busy,
    output logic [N_CH-1:0]   o_done
);
    localparam int PW = N_CH > 1 ? $clog2(N_CH) : 1;
    logic [30:0]     lcg_r, lcg_nxt;
    logic [3:0]      lcg_val;
    logic [N_CH-1:0] req, gnt;
    logic [PW-1:0]   ptr, gidx, cand;
    lcg_step u_lcg (.state(lcg_r), .next(lcg_nxt), .value(lcg_val));
    // Walk from farthest to nearest so the channel closest after ptr wins
    always_comb begin
        gnt  = '0;
        gidx = ptr;
        cand = ptr;
        for (int i = N_CH; i >= 1; i--) begin
            cand = PW'((int'(ptr) + i) % N_CH);
            if (req[cand] && !i_seed_load) begin
                gidx = cand;
                gnt = '0;
                gnt[cand] = 1'b1;
            end
        end
    end
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            lcg_r <= '0;
            ptr   <= PW'(N_CH - 1);
        end else begin
            lcg_r <= i_seed_load ? i_seed : (|gnt ? lcg_nxt : lcg_r);
            ptr   <= |gnt ? gidx : ptr;
        end
    end
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        ch_state_e        st, st_n;
        logic [3:0]       k, k_n, val_r;
        logic [CNT_W-1:0] tm, tm_n, ival;
        logic             fin, done_r;
        assign ival   = CNT_W'(BASE_TICKS) << (k >> 2);
        assign req[c] = (st == REQ) && !i_start[c];
        always_comb begin
            st_n = st;
            k_n  = k;
            tm_n = tm;
            fin  = 1'b0;
            if (i_start[c]) begin
                st_n = WAIT;
                k_n  = '0;
                tm_n = '0;
            end else if (st == WAIT) begin
                st_n = (tm == ival - 1'b1) ? REQ : WAIT;
                tm_n = tm + 1'b1;
            end else if (gnt[c]) begin
                fin  = (k == 4'(STEPS - 1));
                st_n = fin ? IDLE : WAIT;
                k_n  = k + 1'b1;
                tm_n = '0;
            end
        end
        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                st     <= IDLE;
                k      <= '0;
                tm     <= '0;
                done_r <= 1'b0;
                val_r  <= '0;
            end else begin
                st     <= st_n;
                k      <= k_n;
                tm     <= tm_n;
                done_r <= fin;
                val_r  <= gnt[c] ? lcg_val : val_r;
            end
        end
        assign o_busy[c]          = (st != IDLE);
        assign o_done[c]          = done_r;
        assign o_value[4*c +: 4]  = val_r;
    end
endmodule

// File: tb/tb_roll_scheduler.sv
// tb_roll_scheduler: randomized and directed stimulus scored against a due-time reference model
module tb_roll_scheduler;
    localparam int N  = 2;
    localparam int ST = 6;
    localparam int BT = 2;
    typedef struct packed {
        logic [4*N-1:0] v;
        logic [N-1:0]   b;
        logic [N-1:0]   d;
    } snap_t;
    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   start;
    logic           sl;
    logic [30:0]    seed;
    logic [4*N-1:0] o_value;
    logic [N-1:0]   o_busy, o_done;
    int             pass_cnt = 0, tot_cnt = 0;
    snap_t          q[$];
    // Reference model: channels tracked by the edge at which they may next be granted
    bit             m_act[N];
    int             m_k[N];
    longint         m_due[N];
    logic [3:0]     m_val[N];
    logic [N-1:0]   m_done;
    int             m_ptr;
    logic [30:0]    m_lcg;
    longint         n;

    roll_scheduler #(.N_CH(N), .STEPS(ST), .BASE_TICKS(BT), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_seed_load(sl), .i_seed(seed),
        .o_value(o_value), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] lcg_next(logic [30:0] s);
        longint t = longint'(s) * 64'd1103515245 + 64'd12345;
        return t[30:0];
    endfunction

    function automatic longint iv(int k);
        return longint'(BT) << (k / 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic model_step(input logic r, input logic [N-1:0] s, input logic ld, input logic [30:0] sd);
        int    g = -1;
        snap_t e;
        m_done = '0;
        if (!r) begin
            for (int c = 0; c < N; c++) begin
                m_act[c] = 0; m_k[c] = 0; m_due[c] = 0; m_val[c] = 0;
            end
            m_ptr = N - 1;
            m_lcg = '0;
        end else begin
            n++;
            if (!ld)
                for (int i = 1; i <= N; i++) begin
                    int c = (m_ptr + i) % N;
                    if (g < 0 && m_act[c] && n >= m_due[c] && !s[c]) g = c;
                end
            if (ld) m_lcg = sd;
            else if (g >= 0) begin
                m_lcg = lcg_next(m_lcg);
                m_val[g] = {m_lcg[15], m_lcg[14], m_lcg[3], m_lcg[13]};
                m_ptr = g;
                if (m_k[g] == ST - 1) begin
                    m_act[g] = 0;
                    m_done[g] = 1'b1;
                end else begin
                    m_k[g]++;
                    m_due[g] = n + iv(m_k[g]) + 1;
                end
            end
            for (int c = 0; c < N; c++)
                if (s[c]) begin
                    m_act[c] = 1; m_k[c] = 0; m_due[c] = n + iv(0) + 1;
                end
        end
        for (int c = 0; c < N; c++) begin
            e.v[4*c +: 4] = m_val[c];
            e.b[c] = m_act[c];
        end
        e.d = m_done;
        q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] s, input logic ld, input logic [30:0] sd);
        rst = r; start = s; sl = ld; seed = sd;
        if (!r) begin
            #1;
            check("async_reset", {o_value, o_busy, o_done}, '0);
        end
        model_step(r, s, ld, sd);
        @(negedge clk);
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) cycle(1'b1, '0, 1'b0, '0);
    endtask

    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("cycle_outputs", {o_value, o_busy, o_done}, e);
            end
        end
    end

    initial begin
        n = 0;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, '0);
        check("reset_state", {o_value, o_busy, o_done}, '0);
        cycle(1'b1, 2'b11, 1'b0, '0);
        check("busy_after_start", o_busy, 2'b11);
        idle(3);
        check("contend_ch0_first", o_value, 8'h03);
        idle(1);
        check("contend_ch1_second", o_value[7:4], 4'd2);
        idle(2);
        cycle(1'b0, '0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0);
        cycle(1'b1, 2'b01, 1'b0, '0);
        idle(3);
        check("reseed_first", o_value[3:0], 4'd3);
        idle(3);
        check("reseed_second", o_value[3:0], 4'd2);
        cycle(1'b1, 2'b01, 1'b0, '0);
        idle(2);
        cycle(1'b1, '0, 1'b1, '0);
        check("seed_blocks_grant", o_value[3:0], 4'd2);
        idle(1);
        check("grant_after_seed", o_value[3:0], 4'd3);
        for (int i = 0; i < 3000; i++)
            cycle(1'b1, {($urandom_range(0, 79) == 0), ($urandom_range(0, 79) == 0)},
                  ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom));
        idle(80);
        check("all_idle_at_end", o_busy, '0);
        @(posedge clk);
        #2;
        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/roll_scheduler.md
# roll_scheduler

Multi-channel roll sequencer for the dice/random-display lab. It owns the single shared 31-bit LCG state and runs one decelerating roll schedule per channel: a fast burst of value updates that slows down, then a hold on the final value. Channels request LCG steps, and a round-robin arbiter grants at most one step per cycle. Per-channel 4-bit values feed the seven-segment decoders.

## Interface
- N_CH, default 2: number of independent roll channels (1..4).
- STEPS, default 13: value updates per roll (1..16).
- BASE_TICKS, default 12_500_000: length of the first interval in cycles (≥1); benches override with a small value.
- CNT_W, default 32: interval timer width; must hold BASE_TICKS << ((STEPS-1)/4).
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_start  in  N_CH  per-channel start/restart, sampled every cycle.
- i_seed_load  in  1  load i_seed into the LCG state.
- i_seed  in  31  seed value.
- o_value  out  4*N_CH  channel c occupies bits [4c+3:4c], registered.
- o_busy  out  N_CH  channel is rolling.
- o_done  out  N_CH  one-cycle pulse when a roll completes.

## Operation
- LCG step: next = (lcg * 1103515245 + 12345) mod 2^31. Product is truncated to 31 bits.
- Extracted value: {next[15], next[14], next[3], next[13]}.
- Interval for step k (0-based) is BASE_TICKS << (k/4), using integer division.
- Each channel has its own FSM with three states.
  - IDLE: o_busy=0. On start, go to WAIT with k=0 and timer=0.
  - WAIT: timer counts 0..interval_k-1. After the last count, go to REQ.
  - REQ: assert request and stay until granted.
    - On grant with k<STEPS-1: k++, timer=0, go to WAIT.
    - On grant with k=STEPS-1: go to IDLE.
- On grant to channel c, the same edge does both of these:
  - lcg_r ← next.
  - value of channel c ← extract(next).
- Only the granted channel's value changes. Values hold while idle.
- The LCG advances only on a grant or a seed load. It does not free-run.
- Arbiter: combinational and round-robin over REQ channels.
  - A last-grant pointer is updated on every grant.
  - Search starts at pointer+1. After reset the pointer is N_CH-1, so channel 0 has first priority.
- Boundary rules:
  - i_start while busy restarts that channel: k=0, timer=0, state WAIT, no done pulse. A grant to that channel in the same cycle is suppressed.
  - i_seed_load has priority over any grant. No grant is issued that cycle and the requesters stay in REQ.
  - i_start in the same cycle as a channel's final grant: the restart wins and o_done is not pulsed.
  - Several channels starting together all enter WAIT. Any REQ collisions are serialized by the arbiter.

## Timing
- Reset values:
  - o_value, o_busy, o_done: all 0.
  - lcg_r: 0.
  - All FSMs: IDLE.
  - Arbiter pointer: N_CH-1.
- Start at edge t gives o_busy=1 after edge t.
- Uncontended step k lasts interval_k + 1 cycles. The value is visible after edge t + Σ_{j≤k}(interval_j + 1).
- Contention adds one cycle per losing grant. Worst-case wait is N_CH-1 cycles.
- Final grant edge: value updates, o_busy falls and o_done pulses, all on the same edge. o_done is high for exactly one cycle.
- Seed load takes effect after its edge. The next grant uses the loaded seed.

## Structure
- Package roll_pkg holds:
  - LCG_MUL = 1103515245 and LCG_INC = 12345.
  - The channel state enum {IDLE, WAIT, REQ}.
  - A function extract(logic [30:0]) returning logic [3:0].
- Sub-module lcg_step: combinational, input 31-bit state, outputs 31-bit next and 4-bit value.
- The FSMs, timers and arbiter live in roll_scheduler using a generate loop over channels.

## Test plan
- Single channel, reset seed: N_CH=1, BASE_TICKS=4, STEPS=3, start at edge 0.
  - o_value=3 after edge 5, then 2 after edge 10.
  - o_done pulses after edge 15 together with o_busy falling.
- Deceleration: BASE_TICKS=2, STEPS=9. Gaps between value changes are 3,3,3,3,5,5,5,5,9 cycles.
- Contention: N_CH=2, both start on the same edge.
  - First REQ cycle: channel 0 granted, channel 1 granted one cycle later.
  - Channel 1 gets extract of the second LCG output (2). Later collisions alternate priority.
- Restart mid-roll: i_start at step 2 resets k. The full STEPS updates follow, with no o_done before the final one.
- Seed load against REQ: assert i_seed_load=1 with i_seed=0 while channel 0 is in REQ.
  - No grant that cycle. The next-cycle grant yields value 3.
- Async reset mid-roll: asserting i_rst clears all outputs immediately. After release, a start reproduces the reset-seed sequence 3, 2.
